// File: rtl/ece385_sprite_bank_if.sv
// Avalon-MM bus bundle between the CPU master and the sprite bank slave.
// The address MSB selects CSR space; the remaining bits address a RAM word.
interface ece385_sprite_bank_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
);
   logic [ADDR_W:0]       address;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [DATA_W/8-1:0]   byteenable;
   logic [DATA_W-1:0]     writedata;
   logic [DATA_W-1:0]     readdata;
   logic                  readdatavalid;

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/ece385_sprite_bank.sv
// Multi-bank sprite memory: the CPU edits the "cpu bank" over Avalon-MM while
// the renderer reads pixels from the "front bank". A requested bank swap is
// held pending and only applied on a vsync pulse so a frame never tears.
module ece385_sprite_bank #(
   parameter int    DATA_W    = 32,
   parameter int    PIX_W     = 16,
   parameter int    ADDR_W    = 11,
   parameter int    NBANKS    = 2,
   parameter string INIT_FILE = "ece385_sprite_bank.hex"
) (
   input  logic                                        clk,
   input  logic                                        reset,
   ece385_sprite_bank_if.slave                         avs,
   input  logic                                        vsync,
   input  logic                                        pix_rd,
   input  logic [ADDR_W+$clog2(DATA_W/PIX_W)-1:0]      pix_addr,
   output logic [PIX_W-1:0]                            pix_data,
   output logic                                        pix_valid,
   output logic [$clog2(NBANKS)-1:0]                   front_bank
);

   localparam int RATIO      = DATA_W / PIX_W;
   localparam int LANE_W     = $clog2(RATIO);
   localparam int LANE_SEL_W = (LANE_W > 0) ? LANE_W : 1;
   localparam int BANK_W     = $clog2(NBANKS);
   localparam int BE_W       = DATA_W / 8;
   localparam int IDX_W      = BANK_W + ADDR_W;
   localparam int DEPTH      = NBANKS * (2 ** ADDR_W);

   // Backing store for all banks; the FPGA flow preloads bank 0 from INIT_FILE.
   (* ram_init_file = INIT_FILE *)
   logic [DATA_W-1:0] mem_q [DEPTH];

   // Record at elaboration whether a preload image was named at all.
   if (INIT_FILE == "") begin : g_no_init_file
   end else begin : g_init_file
   end

   // Architectural state
   logic [BANK_W-1:0] front_bank_d,   front_bank_q;
   logic [BANK_W-1:0] cpu_bank_d,     cpu_bank_q;
   logic [BANK_W-1:0] pending_bank_d, pending_bank_q;
   logic              swap_pending_d, swap_pending_q;

   // Registered outputs
   logic [DATA_W-1:0] readdata_d,      readdata_q;
   logic              readdatavalid_d, readdatavalid_q;
   logic [PIX_W-1:0]  pix_data_d,      pix_data_q;
   logic              pix_valid_d,     pix_valid_q;

   // Bus decode
   logic              csr_sel_s;
   logic              cs_rd_s;
   logic              cs_wr_s;
   logic              ram_we_s;
   logic              csr_we_s;
   logic [IDX_W-1:0]  cpu_idx_s;
   logic [DATA_W-1:0] csr_rd_s;

   // Pixel path
   logic [ADDR_W-1:0]     pix_word_addr_s;
   logic [LANE_SEL_W-1:0] pix_lane_s;
   logic [IDX_W-1:0]      pix_idx_s;
   logic [DATA_W-1:0]     pix_word_s;
   logic [PIX_W-1:0]      pix_lane_data_s;

   assign csr_sel_s = avs.address[ADDR_W];
   assign cs_rd_s   = avs.chipselect & avs.read;
   assign cs_wr_s   = avs.chipselect & avs.write;
   assign ram_we_s  = cs_wr_s & ~csr_sel_s;
   assign csr_we_s  = cs_wr_s & csr_sel_s;
   assign cpu_idx_s = {cpu_bank_q, avs.address[ADDR_W-1:0]};

   // Split the pixel index into word address and lane; one lane needs no select bits.
   if (LANE_W > 0) begin : g_lanes
      assign pix_lane_s      = pix_addr[LANE_W-1:0];
      assign pix_word_addr_s = pix_addr[ADDR_W+LANE_W-1:LANE_W];
   end else begin : g_one_lane
      assign pix_lane_s      = '0;
      assign pix_word_addr_s = pix_addr;
   end

   // The front bank is taken as it stands in the request cycle.
   assign pix_idx_s = {front_bank_q, pix_word_addr_s};

   // Fetch the addressed pixel word and pick the requested lane (lane 0 = LSBs).
   always_comb begin
      pix_word_s      = mem_q[pix_idx_s];
      pix_lane_data_s = pix_word_s[int'(pix_lane_s) * PIX_W +: PIX_W];
   end

   // CSR read mux; unused bits and the reserved register read as zero.
   always_comb begin
      csr_rd_s = '0;
      case (avs.address[1:0])
         2'd0: begin
            csr_rd_s[8]          = swap_pending_q;
            csr_rd_s[BANK_W-1:0] = front_bank_q;
         end
         2'd1: csr_rd_s[BANK_W-1:0] = cpu_bank_q;
         2'd2: csr_rd_s[BANK_W-1:0] = pending_bank_q;
         2'd3: csr_rd_s = '0;
         default: csr_rd_s = '0;
      endcase
   end

   // Next-state logic for bank control and both read ports.
   always_comb begin
      front_bank_d    = front_bank_q;
      cpu_bank_d      = cpu_bank_q;
      pending_bank_d  = pending_bank_q;
      swap_pending_d  = swap_pending_q;
      readdata_d      = readdata_q;
      readdatavalid_d = cs_rd_s;
      pix_data_d      = pix_data_q;
      pix_valid_d     = pix_rd;

      // Reads see state before any same-cycle write (memory writes are non-blocking).
      if (cs_rd_s) begin
         if (csr_sel_s) begin
            readdata_d = csr_rd_s;
         end else begin
            readdata_d = mem_q[cpu_idx_s];
         end
      end else begin
         readdata_d = readdata_q;
      end

      if (pix_rd) begin
         pix_data_d = pix_lane_data_s;
      end else begin
         pix_data_d = pix_data_q;
      end

      // vsync consumes the pending value first, so a coincident CSR 2 write re-arms.
      if (vsync && swap_pending_q) begin
         front_bank_d   = pending_bank_q;
         swap_pending_d = 1'b0;
      end else begin
         front_bank_d   = front_bank_q;
      end

      if (csr_we_s) begin
         case (avs.address[1:0])
            2'd1: cpu_bank_d = avs.writedata[BANK_W-1:0];
            2'd2: begin
               pending_bank_d = avs.writedata[BANK_W-1:0];
               swap_pending_d = 1'b1;
            end
            default: begin
               cpu_bank_d     = cpu_bank_q;
            end
         endcase
      end else begin
         pending_bank_d = pending_bank_q;
      end
   end

   // State and output registers with synchronous reset; RAM is left untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         front_bank_q    <= '0;
         cpu_bank_q      <= BANK_W'(1);
         pending_bank_q  <= '0;
         swap_pending_q  <= 1'b0;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
         pix_data_q      <= '0;
         pix_valid_q     <= 1'b0;
      end else begin
         front_bank_q    <= front_bank_d;
         cpu_bank_q      <= cpu_bank_d;
         pending_bank_q  <= pending_bank_d;
         swap_pending_q  <= swap_pending_d;
         readdata_q      <= readdata_d;
         readdatavalid_q <= readdatavalid_d;
         pix_data_q      <= pix_data_d;
         pix_valid_q     <= pix_valid_d;
      end
   end

   // Byte-lane CPU writes into the cpu bank.
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         for (int b = 0; b < BE_W; b++) begin
            if (avs.byteenable[b]) begin
               mem_q[cpu_idx_s][b*8 +: 8] <= avs.writedata[b*8 +: 8];
            end
         end
      end
   end

   assign avs.readdata      = readdata_q;
   assign avs.readdatavalid = readdatavalid_q;
   assign pix_data          = pix_data_q;
   assign pix_valid         = pix_valid_q;
   assign front_bank        = front_bank_q;

endmodule

// File: tb/tb_ece385_sprite_bank.sv
// Self-checking bench: directed test-plan steps followed by random traffic,
// all compared against a word-array reference model of the sprite bank.
module tb_ece385_sprite_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        vsync;
   logic        pix_rd;
   logic [11:0] pix_addr;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic [0:0]  front_bank;

   ece385_sprite_bank_if #(.DATA_W(32), .ADDR_W(11)) bus ();

   ece385_sprite_bank #(
      .DATA_W(32), .PIX_W(16), .ADDR_W(11), .NBANKS(2),
      .INIT_FILE("ece385_sprite_bank.hex")
   ) dut (
      .clk(clk), .reset(reset), .avs(bus), .vsync(vsync),
      .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
      .pix_valid(pix_valid), .front_bank(front_bank)
   );

   always #5 clk = ~clk;

   // Reference model
   logic [31:0] ref_mem [0:4095];
   int          m_front, m_cpu, m_pending;
   bit          m_pend;
   logic [31:0] exp_rd;
   bit          exp_rdv;
   logic [15:0] exp_pix;
   bit          exp_pv;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a);
      if (a[11]) begin
         case (a[1:0])
            2'd0:    return 32'((m_pend ? 256 : 0) + m_front);
            2'd1:    return 32'(m_cpu);
            2'd2:    return 32'(m_pending);
            default: return 32'h0;
         endcase
      end
      return ref_mem[m_cpu * 2048 + int'(a[10:0])];
   endfunction

   // One clock of stimulus: drive, advance the model, then check after the edge.
   task automatic cycle(input bit rst, input bit cs, input bit rd, input bit wr,
                        input logic [11:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input bit vs, input bit prd,
                        input logic [11:0] paddr);
      logic [31:0] w;
      int          idx;
      @(negedge clk);
      reset = rst;
      bus.chipselect = cs; bus.read = rd; bus.write = wr;
      bus.address = addr; bus.byteenable = be; bus.writedata = wd;
      vsync = vs; pix_rd = prd; pix_addr = paddr;
      if (rst) begin
         exp_rdv = 0; exp_rd = 32'h0; exp_pv = 0; exp_pix = 16'h0;
         m_front = 0; m_cpu = 1; m_pending = 0; m_pend = 0;
      end else begin
         exp_rdv = cs && rd;
         if (exp_rdv) exp_rd = model_read(addr);
         exp_pv = prd;
         if (prd) begin
            w = ref_mem[m_front * 2048 + int'(paddr) / 2];
            exp_pix = (paddr % 2 == 1) ? w[31:16] : w[15:0];
         end
         if (vs && m_pend) begin
            m_front = m_pending;
            m_pend  = 0;
         end
         if (cs && wr) begin
            if (addr[11]) begin
               if (addr[1:0] == 2'd1) m_cpu = int'(wd[0]);
               if (addr[1:0] == 2'd2) begin
                  m_pending = int'(wd[0]);
                  m_pend    = 1;
               end
            end else begin
               idx = m_cpu * 2048 + int'(addr[10:0]);
               for (int b = 0; b < 4; b++)
                  if (be[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
            end
         end
      end
      @(posedge clk);
      #1;
      check("readdatavalid", 32'(bus.readdatavalid), 32'(exp_rdv));
      if (exp_rdv) check("readdata", bus.readdata, exp_rd);
      check("pix_valid", 32'(pix_valid), 32'(exp_pv));
      check("pix_data", 32'(pix_data), 32'(exp_pix));
      check("front_bank", 32'(front_bank), 32'(m_front));
   endtask

   task automatic idle();                       cycle(0,0,0,0,12'h0,4'h0,32'h0,0,0,12'h0); endtask
   task automatic do_reset();                   cycle(1,0,0,0,12'h0,4'h0,32'h0,0,0,12'h0); endtask
   task automatic csr_wr(input int a, input logic [31:0] d); cycle(0,1,0,1,12'h800 | 12'(a),4'hF,d,0,0,12'h0); endtask
   task automatic csr_rd(input int a);          cycle(0,1,1,0,12'h800 | 12'(a),4'h0,32'h0,0,0,12'h0); endtask
   task automatic ram_wr(input int a, input logic [3:0] be, input logic [31:0] d); cycle(0,1,0,1,12'(a),be,d,0,0,12'h0); endtask
   task automatic ram_rd(input int a);          cycle(0,1,1,0,12'(a),4'h0,32'h0,0,0,12'h0); endtask
   task automatic pix(input int p);             cycle(0,0,0,0,12'h0,4'h0,32'h0,0,1,12'(p)); endtask
   task automatic vs_pulse();                   cycle(0,0,0,0,12'h0,4'h0,32'h0,1,0,12'h0); endtask

   initial begin
      bit          r_rst, r_cs, r_rd, r_wr, r_vs, r_prd;
      logic [11:0] r_addr, r_paddr;
      reset = 1'b1; vsync = 1'b0; pix_rd = 1'b0; pix_addr = 12'h0;
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = 12'h0; bus.byteenable = 4'h0; bus.writedata = 32'h0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;

      // Reset state and CSR readback
      do_reset(); do_reset();
      csr_rd(0); check("tp_csr0", bus.readdata, 32'h0);
      check("tp_csr0_valid", 32'(bus.readdatavalid), 32'h1);
      idle();    check("tp_rdv_one_cycle", 32'(bus.readdatavalid), 32'h0);
      csr_rd(1); check("tp_csr1", bus.readdata, 32'h1);

      // Preset the words exercised below in both banks
      for (int i = 0; i < 16; i++) ram_wr(i, 4'hF, 32'h0);
      csr_wr(1, 32'h0);
      for (int i = 0; i < 16; i++) ram_wr(i, 4'hF, 32'h0);
      csr_wr(1, 32'h1);

      // Byte-lane write, readback, swap and pixel lanes
      ram_wr(5, 4'b0011, 32'hDEADBEEF);
      ram_rd(5);  check("tp_beef_word", bus.readdata, 32'h0000BEEF);
      csr_wr(2, 32'h1);
      vs_pulse(); check("tp_swap_to_1", 32'(front_bank), 32'h1);
      pix(10);    check("tp_pix_lane0", 32'(pix_data), 32'h0000BEEF);
      pix(11);    check("tp_pix_lane1", 32'(pix_data), 32'h0);
      idle();     check("tp_pix_hold", 32'(pix_data), 32'h0);

      // Second pending write overrides the first; vsync alone does nothing
      csr_wr(2, 32'h1); csr_wr(2, 32'h0);
      vs_pulse(); check("tp_override_front", 32'(front_bank), 32'h0);
      csr_rd(0);  check("tp_override_csr0", bus.readdata, 32'h0);
      vs_pulse(); check("tp_no_pending", 32'(front_bank), 32'h0);

      // CSR 2 write coincident with vsync
      csr_wr(2, 32'h1);
      cycle(0,1,0,1,12'h802,4'hF,32'h0,1,0,12'h0);
      check("tp_coincident_front", 32'(front_bank), 32'h1);
      csr_rd(0);  check("tp_coincident_csr0", bus.readdata, 32'h101);
      vs_pulse(); check("tp_coincident_swap", 32'(front_bank), 32'h0);

      // Pixel read during CPU write to the same front-bank word
      csr_wr(1, 32'h0);
      ram_wr(3, 4'hF, 32'hAAAA5555);
      cycle(0,1,0,1,12'd3,4'hF,32'h12345678,0,1,12'd6);
      check("tp_rdw_old", 32'(pix_data), 32'h5555);
      pix(6);     check("tp_rdw_new", 32'(pix_data), 32'h5678);

      // Reset mid-operation
      csr_wr(2, 32'h1); vs_pulse();
      cycle(0,1,1,0,12'd3,4'h0,32'h0,0,1,12'd6);
      do_reset();
      check("tp_rst_pv", 32'(pix_valid), 32'h0);
      check("tp_rst_rdv", 32'(bus.readdatavalid), 32'h0);
      check("tp_rst_front", 32'(front_bank), 32'h0);
      csr_rd(1);  check("tp_rst_cpu", bus.readdata, 32'h1);
      csr_wr(1, 32'h0);
      ram_rd(3);  check("tp_ram_survives", bus.readdata, 32'h12345678);

      // Random traffic within the preset window
      for (int n = 0; n < 400; n++) begin
         r_rst = ($urandom_range(0, 99) == 0);
         r_cs  = !r_rst && ($urandom_range(0, 3) != 0);
         r_rd  = $urandom_range(0, 1);
         r_wr  = $urandom_range(0, 1);
         if ($urandom_range(0, 2) == 0)
            r_addr = {1'b1, 9'($urandom), 2'($urandom)};
         else
            r_addr = {1'b0, 7'h0, 4'($urandom)};
         r_vs    = ($urandom_range(0, 7) == 0);
         r_prd   = !r_rst && ($urandom_range(0, 1) == 1);
         r_paddr = {7'h0, 5'($urandom)};
         cycle(r_rst, r_cs, r_rd, r_wr, r_addr, 4'($urandom), $urandom,
               r_vs, r_prd, r_paddr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
